// File: rtl/seq_priority_encoder.sv
// Sequential N-to-log2(N) encoder: emits set-bit indices one per handshake.
// Define SEQ_ENC_MSB_FIRST_EN to emit the highest set index first.
module seq_priority_encoder #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         req_valid,
    output logic         req_ready,
    output logic [W-1:0] code_o,
    output logic         code_valid,
    input  logic         code_ready,
    output logic         code_last,
    output logic         busy
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    state_e         state_q;
    logic [N-1:0]   pending_q;
    logic [N-1:0]   pending_d;
    logic [W-1:0]   code_q;
    logic           valid_q;
    logic           last_q;
    logic           busy_q;
    logic [W-1:0]   first_idx;
    logic [W-1:0]   next_idx;

    // Later loop iterations win, so the scan order sets the priority.
    function automatic logic [W-1:0] pick(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
`ifdef SEQ_ENC_MSB_FIRST_EN
        for (int i = 0; i < N; i++)
            if (v[i]) idx = W'(i);
`else
        for (int i = N - 1; i >= 0; i--)
            if (v[i]) idx = W'(i);
`endif
        return idx;
    endfunction

    function automatic logic single(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    always_comb begin
        pending_d = pending_q & ~(N'(1) << code_q);
        first_idx = pick(req_i);
        next_idx  = pick(pending_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid && (req_i != '0)) begin
                        pending_q <= req_i;
                        code_q    <= first_idx;
                        last_q    <= single(req_i);
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= EMIT;
                    end
                end
                EMIT: begin
                    if (valid_q && code_ready) begin
                        pending_q <= pending_d;
                        if (pending_d != '0) begin
                            code_q <= next_idx;
                            last_q <= single(pending_d);
                        end else begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign code_o     = code_q;
    assign code_valid = valid_q;
    assign code_last  = last_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Bench for seq_priority_encoder: queue model plus directed literal checks.
module tb_seq_priority_encoder;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_i;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] code_o;
    logic         code_valid;
    logic         code_ready;
    logic         code_last;
    logic         busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int exp_q[$];

    seq_priority_encoder #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .code_o     (code_o),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_last  (code_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: the list of indices still owed, in emission order.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            if (code_ready) void'(exp_q.pop_front());
        end else if (req_valid) begin
`ifdef SEQ_ENC_MSB_FIRST_EN
            for (int i = N - 1; i >= 0; i--)
                if (req_i[i]) exp_q.push_back(i);
`else
            for (int i = 0; i < N; i++)
                if (req_i[i]) exp_q.push_back(i);
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_valid", int'(code_valid), int'(exp_q.size() > 0));
            check("m_busy", int'(busy), int'(exp_q.size() > 0));
            check("m_ready", int'(req_ready), int'(exp_q.size() == 0));
            check("m_last", int'(code_last), int'(exp_q.size() == 1));
            if (exp_q.size() > 0)
                check("m_code", int'(code_o), exp_q[0]);
        end
    end

    function automatic int ord(input int k);
`ifdef SEQ_ENC_MSB_FIRST_EN
        return 3 - k;
`else
        return k;
`endif
    endfunction

    initial begin
        rst_n      = 1'b0;
        req_i      = '0;
        req_valid  = 1'b0;
        code_ready = 1'b1;
        repeat (2) step();
        chk_en = 1'b1;
        check("rst_valid", int'(code_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(req_ready), 1);
        check("rst_code", int'(code_o), 0);
        check("rst_last", int'(code_last), 0);
        rst_n = 1'b1;

        // Single bit
        req_i = 4'b0100; req_valid = 1'b1;
        step();
        req_i = '0; req_valid = 1'b0;
        check("sb_code", int'(code_o), 2);
        check("sb_valid", int'(code_valid), 1);
        check("sb_last", int'(code_last), 1);
        step();
        check("sb_valid_end", int'(code_valid), 0);
        check("sb_ready_end", int'(req_ready), 1);

        // All bits, no stall
        req_i = 4'b1111; req_valid = 1'b1;
        step();
        req_i = '0; req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("all_code", int'(code_o), ord(k));
            check("all_last", int'(code_last), int'(k == 3));
            check("all_ready", int'(req_ready), 0);
            step();
        end
        check("all_valid_end", int'(code_valid), 0);

        // Backpressure
        code_ready = 1'b0;
        req_i = 4'b1001; req_valid = 1'b1;
        step();
        req_i = '0; req_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("bp_code", int'(code_o), ord(0));
            check("bp_valid", int'(code_valid), 1);
            step();
        end
        code_ready = 1'b1;
        check("bp_hold", int'(code_o), ord(0));
        step();
        check("bp_code2", int'(code_o), ord(3));
        check("bp_last2", int'(code_last), 1);
        step();
        check("bp_idle", int'(req_ready), 1);
        check("bp_valid_end", int'(code_valid), 0);

        // Zero vector is accepted and dropped
        req_i = '0; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("zero_valid", int'(code_valid), 0);
        check("zero_busy", int'(busy), 0);
        check("zero_ready", int'(req_ready), 1);

        // Request during EMIT is ignored
        code_ready = 1'b0;
        req_i = 4'b1001; req_valid = 1'b1;
        step();
        req_i = 4'b0010;
        step();
        code_ready = 1'b1;
        step();
        check("ign_code", int'(code_o), ord(3));
        step();
        req_valid = 1'b0; req_i = '0;
        check("ign_idle_valid", int'(code_valid), 0);
        step();
        check("ign_never1", int'(code_valid), 0);

        // Reset mid-emission
        req_i = 4'b1111; req_valid = 1'b1;
        step();
        req_i = '0; req_valid = 1'b0;
        check("rm_code0", int'(code_o), ord(0));
        step();
        rst_n = 1'b0;
        step();
        check("rm_valid", int'(code_valid), 0);
        check("rm_busy", int'(busy), 0);
        check("rm_ready", int'(req_ready), 1);
        rst_n = 1'b1;
        req_i = 4'b0100; req_valid = 1'b1;
        step();
        req_i = '0; req_valid = 1'b0;
        check("rm_code", int'(code_o), 2);
        check("rm_last", int'(code_last), 1);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_priority_encoder.md
Name: seq_priority_encoder

Overview:
- Sequential N-to-log2(N) encoder; the inverse direction of the team's line decoders.
- Captures an N-bit request vector through a valid/ready handshake.
- Emits the index of each set bit, one per output handshake, in priority order (lowest index first by default). `code_last` marks the final index.
- Sits between interrupt/request sources and any consumer that takes binary indices, e.g. a downstream decoder selecting one of N lines.

Parameters:
- N, 4, number of request lines; must be a power of two, N >= 2.
- W, 2, code width; must equal log2(N).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- req_i  input  N  request vector; bit i set means index i is to be encoded
- req_valid  input  1  req_i is valid this cycle
- req_ready  output  1  block can accept a request vector
- code_o  output  W  binary index of the current set bit
- code_valid  output  1  code_o / code_last are valid
- code_ready  input  1  consumer accepts code_o this cycle
- code_last  output  1  code_o is the final index of the captured vector
- busy  output  1  a captured vector is still being emitted

Behaviour:
- Reset (rst_n low at a clk edge) forces:
  - state to IDLE and the pending register to 0
  - `code_o`, `code_valid`, `code_last` and `busy` to 0
  - `req_ready` to 1
- Reset mid-emission discards all pending bits and does not complete the current code.
- State IDLE:
  - `req_ready` = 1; `code_valid` = 0; `busy` = 0.
  - On an edge with `req_valid` = 1 and `req_i` != 0:
    - pending <= `req_i`
    - `code_o` <= index of the highest-priority set bit of `req_i`
    - `code_last` <= 1 if `req_i` has exactly one set bit
    - `code_valid` <= 1; `busy` <= 1; go to EMIT
  - On an edge with `req_valid` = 1 and `req_i` == 0: the vector is accepted and dropped. No output, and the block stays in IDLE.
- State EMIT:
  - `req_ready` = 0; `req_valid` is ignored.
  - `code_o`, `code_valid` and `code_last` are held stable while `code_ready` = 0.
  - On an edge with `code_valid` & `code_ready`, the bit at `code_o` is cleared from pending.
    - If remaining pending != 0: `code_o` <= next-priority index and `code_last` recomputed. `code_valid` stays 1, giving back-to-back throughput of one code per cycle.
    - If remaining pending == 0: `code_valid` <= 0, `code_last` <= 0, `busy` <= 0. Go to IDLE, so `req_ready` is 1 in the next cycle.
- Latency: a request accepted at edge k gives the first code valid after edge k. A vector with M set bits takes M cycles of output when `code_ready` is held at 1.
- Minimum spacing between vectors: one IDLE cycle. A new request is accepted no earlier than the edge after the last code handshake.
- Priority (default): lowest set index first. Example: `req_i` = 4'b1010 emits 1, then 3.
- Outputs are registered, except `req_ready`, which is decoded directly from the state register.
- Width: `code_o` is exactly W bits. N = 2^W covers every index with no wrap.

Optional Feature:
- Macro: SEQ_ENC_MSB_FIRST_EN.
- Defined: priority is reversed and the highest set index is emitted first. Example: 4'b1010 emits 3, then 1.
- Undefined: lowest index first.
- All handshake, `code_last` and latency rules are identical in both builds.

Test Plan:
- Reset mid-emission:
  - Stimulus: capture 4'b1111, emit code 0, then assert rst_n = 0 for one edge.
  - Response: after that edge `code_valid` = 0, `busy` = 0, `req_ready` = 1.
  - Then send a new 4'b0100: emits code 2 with `code_last` = 1.
- Single bit: `req_i` = 4'b0100 with `req_valid` = 1, `code_ready` = 1.
  - Response: one cycle after acceptance, `code_o` = 2, `code_valid` = 1, `code_last` = 1.
  - Next cycle: `code_valid` = 0 and `req_ready` = 1.
- All bits, no stall: `req_i` = 4'b1111 with `code_ready` = 1.
  - Response: `code_o` sequence 0, 1, 2, 3 on consecutive cycles; `code_last` = 1 only with 3.
  - `req_ready` = 0 throughout emission.
  - With SEQ_ENC_MSB_FIRST_EN defined: sequence 3, 2, 1, 0.
- Backpressure: `req_i` = 4'b1001 with `code_ready` held low for 3 cycles.
  - Response: `code_o` = 0 held stable with `code_valid` = 1 for those cycles.
  - After `code_ready` goes high: `code_o` = 3 with `code_last` = 1, then the block returns to IDLE.
- Zero vector and ignored request:
  - `req_i` = 0 with `req_valid` = 1: accepted, no `code_valid` pulse, `busy` stays 0.
  - `req_valid` = 1 with `req_i` = 4'b0010 during EMIT of a prior vector: ignored, and code 1 is never emitted for it.
